ram_dp_fill: RTL

Parametrised true-dual-port synchronous RAM with a built-in fill engine, successor to the fixed 2K×8 video/bullet RAMs in the Tank Battalion simulation. Width, depth and read-during-write mode are set per instance. A hardware sequencer writes a fill value to every location after reset, or on request, so no RAM depends on `initial`/`$readmemh` preload. Used for the playfield, sprite/bullet and work RAMs, with the CPU on port A and video on port B.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_dp_core.sv | 35 +++
 rtl/ram_dp_fill.sv | 108 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the fill-capable dual-port RAM
package ram_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } fill_state_e;

   localparam int RDW_WRITE_FIRST = 0;
   localparam int RDW_READ_FIRST  = 1;

endpackage

// File: rtl/ram_dp_core.sv
// rtl/ram_dp_core.sv - bare true-dual-port array without reset, maps onto block RAM
module ram_dp_core
   import ram_pkg::*;
#(
   parameter int DW       = 8,
   parameter int AW       = 11,
   parameter int RDW_MODE = RDW_WRITE_FIRST
) (
   input  logic          clk,
   input  logic          wr_a,
   input  logic          fwd_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   output logic [DW-1:0] q_a,
   input  logic          wr_b,
   input  logic          fwd_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] din_b,
   output logic [DW-1:0] q_b
);

   logic [DW-1:0] mem [2**AW];

   // fwd_x is separate from wr_x so a port whose write lost a collision still forwards its data
   always_ff @(posedge clk) begin
      if (wr_b) mem[addr_b] <= din_b;
      if (wr_a) mem[addr_a] <= din_a;
   end

   always_ff @(posedge clk) begin
      q_a <= (RDW_MODE == RDW_WRITE_FIRST && fwd_a) ? din_a : mem[addr_a];
      q_b <= (RDW_MODE == RDW_WRITE_FIRST && fwd_b) ? din_b : mem[addr_b];
   end

endmodule

// File: rtl/ram_dp_fill.sv
// rtl/ram_dp_fill.sv - dual-port RAM with hardware fill engine and port lockout while filling
module ram_dp_fill
   import ram_pkg::*;
#(
   parameter int              DW            = 8,
   parameter int              AW            = 11,
   parameter logic [DW-1:0]   FILL_VAL      = '0,
   parameter int              RDW_MODE      = RDW_WRITE_FIRST,
   parameter bit              FILL_ON_RESET = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] data_a,
   input  logic          we_a,
   output logic [DW-1:0] q_a,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] data_b,
   input  logic          we_b,
   output logic [DW-1:0] q_b
);

   localparam logic [AW-1:0] PTR_LAST  = '1;
   localparam fill_state_e   RST_STATE = FILL_ON_RESET ? S_FILL : S_IDLE;

   fill_state_e   state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          done_q, done_d;
   logic          rd_en_q, rd_en_d;

   logic          core_wr_a, core_wr_b, core_fwd_a, core_fwd_b;
   logic [AW-1:0] core_addr_a;
   logic [DW-1:0] core_din_a;
   logic [DW-1:0] core_q_a, core_q_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RST_STATE;
         ptr_q   <= '0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_FILL;
               ptr_d   = '0;
            end
         end
         S_FILL: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
      // q is only trusted for reads sampled on an idle edge that stays idle
      rd_en_d = (state_q == S_IDLE) && (state_d == S_IDLE);
   end

   assign clr_busy = (state_q == S_FILL);
   assign clr_done = done_q;

   // fill engine owns port A's write path while busy; port A wins same-address collisions
   assign core_wr_a   = clr_busy | we_a;
   assign core_addr_a = clr_busy ? ptr_q : addr_a;
   assign core_din_a  = clr_busy ? FILL_VAL : data_a;
   assign core_fwd_a  = !clr_busy && we_a;
   assign core_fwd_b  = !clr_busy && we_b;
   assign core_wr_b   = core_fwd_b && !(we_a && (addr_a == addr_b));

   ram_dp_core #(
      .DW       (DW),
      .AW       (AW),
      .RDW_MODE (RDW_MODE)
   ) u_core (
      .clk    (clk),
      .wr_a   (core_wr_a),
      .fwd_a  (core_fwd_a),
      .addr_a (core_addr_a),
      .din_a  (core_din_a),
      .q_a    (core_q_a),
      .wr_b   (core_wr_b),
      .fwd_b  (core_fwd_b),
      .addr_b (addr_b),
      .din_b  (data_b),
      .q_b    (core_q_b)
   );

   assign q_a = rd_en_q ? core_q_a : '0;
   assign q_b = rd_en_q ? core_q_b : '0;

endmodule
